// File: rtl/line_pattern_gen.sv
// line_pattern_gen
// Raster test-pattern source: emits IMG_W x IMG_H frames of 4-bit pixels in
// raster order. Each row has a vertical bright stripe LINE_WIDTH pixels wide
// starting at a latched column. Every row is followed by H_BLANK idle cycles.
// The stripe column and both levels are sampled once per frame, so changes
// made mid-frame show up in the next frame.
//
// Optional feature (macro LINE_DRIFT_EN): the stripe column drifts one pixel
// per completed frame: (line_x + frame_count) mod IMG_W.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       generate frames while high (sampled at frame boundaries)
//   line_x       stripe start column
//   line_level   stripe pixel value
//   bg_level     background pixel value
//   pixel_out    raster pixel (registered)
//   out_valid    pixel_out valid this cycle (registered)
//   frame_start  high with the first valid pixel of a frame
//   frame_end    high with the last valid pixel of a frame
//   busy         high whenever the generator is not idle
module line_pattern_gen #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int LINE_WIDTH = 8,
  parameter int H_BLANK    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [$clog2(IMG_W)-1:0]  line_x,
  input  logic [3:0]                line_level,
  input  logic [3:0]                bg_level,
  output logic [3:0]                pixel_out,
  output logic                      out_valid,
  output logic                      frame_start,
  output logic                      frame_end,
  output logic                      busy
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_ONE      = XW'(1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_ONE      = YW'(1);
  localparam logic [XW:0]   LW_M1      = (XW + 1)'(LINE_WIDTH - 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [BW-1:0] BLANK_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] blank_cnt;
  logic [XW-1:0] col;
  logic [3:0]    line_lvl;
  logic [3:0]    bg_lvl;

  // Column to latch when starting from IDLE and when chaining frames.
  logic [XW-1:0] start_col;
  logic [XW-1:0] next_col;

`ifdef LINE_DRIFT_EN
  // Completed-frame count kept modulo IMG_W; the chained frame must see the
  // count as it will be after the frame_end that is being emitted.
  logic [XW-1:0] frame_count;
  logic [XW-1:0] frame_count_next;
  localparam logic [XW:0] W_EXT = (XW + 1)'(IMG_W);

  assign frame_count_next = (frame_count == X_LAST) ? '0 : frame_count + X_ONE;
  assign start_col = XW'(({1'b0, line_x} + {1'b0, frame_count}) % W_EXT);
  assign next_col  = XW'(({1'b0, line_x} + {1'b0, frame_count_next}) % W_EXT);
`else
  assign start_col = line_x;
  assign next_col  = line_x;
`endif

  // One extra bit keeps col+LINE_WIDTH-1 from wrapping, so a stripe near the
  // right edge clips at IMG_W-1 instead of reappearing at column 0.
  logic [XW:0] x_ext;
  logic [XW:0] col_ext;
  logic [XW:0] stripe_last;
  logic        in_stripe;

  assign x_ext       = {1'b0, x};
  assign col_ext     = {1'b0, col};
  assign stripe_last = col_ext + LW_M1;
  assign in_stripe   = (x_ext >= col_ext) && (x_ext <= stripe_last);

  // Single FSM; all outputs are registered here. Outputs lag the x/y
  // position by one cycle, so the first pixel appears the cycle after
  // enable is sampled in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      blank_cnt   <= '0;
      col         <= '0;
      line_lvl    <= '0;
      bg_lvl      <= '0;
      pixel_out   <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
`ifdef LINE_DRIFT_EN
      frame_count <= '0;
`endif
    end else begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            col      <= start_col;
            line_lvl <= line_level;
            bg_lvl   <= bg_level;
            x        <= '0;
            y        <= '0;
            state    <= ACTIVE;
            busy     <= 1'b1;
          end
        end

        ACTIVE: begin
          pixel_out   <= in_stripe ? line_lvl : bg_lvl;
          out_valid   <= 1'b1;
          frame_start <= (x == '0) && (y == '0);
          if (x == X_LAST) begin
            x <= '0;
            if (y == Y_LAST) begin
              frame_end <= 1'b1;
              y         <= '0;
`ifdef LINE_DRIFT_EN
              frame_count <= frame_count_next;
`endif
              if (enable) begin
                // Chain straight into the next frame after the row gap.
                col      <= next_col;
                line_lvl <= line_level;
                bg_lvl   <= bg_level;
                if (H_BLANK > 0) begin
                  state     <= HBLANK;
                  blank_cnt <= BLANK_INIT;
                end
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              y <= y + Y_ONE;
              if (H_BLANK > 0) begin
                state     <= HBLANK;
                blank_cnt <= BLANK_INIT;
              end
            end
          end else begin
            x <= x + X_ONE;
          end
        end

        HBLANK: begin
          if (blank_cnt == '0) begin
            state <= ACTIVE;
          end else begin
            blank_cnt <= blank_cnt - BLANK_ONE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_pattern_gen.sv
// tb_line_pattern_gen
// Directed bench for line_pattern_gen (IMG_W=16, IMG_H=8, LINE_WIDTH=2,
// H_BLANK=3). Expected beats are queued when a frame is requested and popped
// by a monitor on every valid output beat. Honours LINE_DRIFT_EN in its model.
module tb_line_pattern_gen;

  localparam int IMG_W      = 16;
  localparam int IMG_H      = 8;
  localparam int LINE_WIDTH = 2;
  localparam int H_BLANK    = 3;
  localparam int BEATS      = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] line_x = '0;
  logic [3:0] line_level = '0;
  logic [3:0] bg_level = '0;
  logic [3:0] pixel_out;
  logic       out_valid;
  logic       frame_start;
  logic       frame_end;
  logic       busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] pix;
    logic       fs;
    logic       fe;
    int         gap;
  } beat_t;

  beat_t exp_q[$];
  int    model_fc = 0;
  int    idle_run = 0;

  always #5 clk = ~clk;

  line_pattern_gen #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .LINE_WIDTH(LINE_WIDTH),
    .H_BLANK(H_BLANK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .line_x(line_x),
    .line_level(line_level),
    .bg_level(bg_level),
    .pixel_out(pixel_out),
    .out_valid(out_valid),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .busy(busy)
  );

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Stripe column the design should latch for the next frame it starts.
  function automatic int exp_col(input int lx);
`ifdef LINE_DRIFT_EN
    return (lx + model_fc) % IMG_W;
`else
    return lx;
`endif
  endfunction

  // Queue one complete frame. first_gap < 0 means no gap check on beat 0.
  task automatic apply_stimulus(input int lx, input int lvl, input int bg, input int first_gap);
    int col;
    beat_t b;
    col = exp_col(lx);
    for (int yy = 0; yy < IMG_H; yy++) begin
      for (int xx = 0; xx < IMG_W; xx++) begin
        b.pix = (xx >= col && xx <= col + LINE_WIDTH - 1) ? 4'(lvl) : 4'(bg);
        b.fs  = (xx == 0 && yy == 0);
        b.fe  = (xx == IMG_W - 1 && yy == IMG_H - 1);
        b.gap = (xx != 0) ? 0 : ((yy == 0) ? first_gap : H_BLANK);
        exp_q.push_back(b);
      end
    end
    model_fc++;
  endtask

  // Wait (bounded) until at most n expected beats remain.
  task automatic wait_left(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() > n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > n)
      check_output("wait_timeout", 16'(exp_q.size()), 16'(n));
  endtask

  // Monitor: compare every valid beat with the scoreboard head and track
  // idle cycles between beats.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle_run = 0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_output("extra_beat", {15'd0, out_valid}, 16'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("pixel", {12'd0, pixel_out}, {12'd0, e.pix});
          check_output("frame_start", {15'd0, frame_start}, {15'd0, e.fs});
          check_output("frame_end", {15'd0, frame_end}, {15'd0, e.fe});
          if (e.gap >= 0)
            check_output("idle_gap", 16'(idle_run), 16'(e.gap));
        end
        idle_run = 0;
      end else begin
        check_output("stray_flags", {14'd0, frame_start, frame_end}, 16'd0);
        idle_run++;
      end
    end
  end

  initial begin
    $display("[TB] reset check");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_pixel", {12'd0, pixel_out}, 16'd0);
    check_output("rst_valid", {15'd0, out_valid}, 16'd0);
    check_output("rst_fs", {15'd0, frame_start}, 16'd0);
    check_output("rst_fe", {15'd0, frame_end}, 16'd0);
    check_output("rst_busy", {15'd0, busy}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_busy", {15'd0, busy}, 16'd0);

    $display("[TB] stripe at 5, enable dropped in row 3");
    line_x = 4'd5; line_level = 4'd15; bg_level = 4'd0;
    apply_stimulus(5, 15, 0, -1);
    enable = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check_output("first_beat_valid", {15'd0, out_valid}, 16'd1);
    check_output("first_beat_start", {15'd0, frame_start}, 16'd1);
    check_output("busy_active", {15'd0, busy}, 16'd1);
    wait_left(BEATS - (3 * IMG_W + 4), 300);
    enable = 1'b0;
    wait_left(0, 400);
    repeat (2) @(negedge clk);
    check_output("done_busy", {15'd0, busy}, 16'd0);
    check_output("done_valid", {15'd0, out_valid}, 16'd0);

    $display("[TB] stripe at right edge");
    line_x = 4'd15; line_level = 4'd9; bg_level = 4'd3;
    apply_stimulus(15, 9, 3, -1);
    enable = 1'b1;
    wait_left(BEATS - 8, 100);
    enable = 1'b0;
    wait_left(0, 400);
    repeat (2) @(negedge clk);
    check_output("edge_busy", {15'd0, busy}, 16'd0);

    $display("[TB] line_x change mid-frame, back-to-back frames");
    line_x = 4'd5; line_level = 4'd12; bg_level = 4'd1;
    apply_stimulus(5, 12, 1, -1);
    enable = 1'b1;
    wait_left(BEATS - 40, 200);
    line_x = 4'd9;
    apply_stimulus(9, 12, 1, H_BLANK);
    wait_left(BEATS - 8, 400);
    enable = 1'b0;
    wait_left(0, 400);
    repeat (2) @(negedge clk);
    check_output("b2b_busy", {15'd0, busy}, 16'd0);

    $display("[TB] reset mid-row");
    line_x = 4'd15; line_level = 4'd7; bg_level = 4'd2;
    apply_stimulus(15, 7, 2, -1);
    enable = 1'b1;
    wait_left(BEATS - 20, 200);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_output("async_valid", {15'd0, out_valid}, 16'd0);
    check_output("async_busy", {15'd0, busy}, 16'd0);
    check_output("async_pixel", {12'd0, pixel_out}, 16'd0);
    exp_q.delete();
    model_fc = 0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(15, 7, 2, -1);
    apply_stimulus(15, 7, 2, H_BLANK);
    enable = 1'b1;
    wait_left(BEATS - 8, 400);
    enable = 1'b0;
    wait_left(0, 400);
    repeat (2) @(negedge clk);
    check_output("final_busy", {15'd0, busy}, 16'd0);
    check_output("final_queue", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
